// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and the priority-search helper for rom_port_arbiter.
// Used by both the round-robin and the ROM_ARB_FIXED_PRIO_EN builds.
package rom_arb_pkg;

    localparam int MAX_REQ = 16;

    function automatic int w_id(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

    // First set bit of valid at or after start, wrapping at n; returns start if none set.
    function automatic req_id_t next_grant(input logic [MAX_REQ-1:0] valid,
                                           input req_id_t start,
                                           input int n);
        req_id_t g;
        req_id_t off;
        req_id_t idx;
        logic    found;
        g     = start;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            off = req_id_t'(i);
            idx = (int'(off) >= n - int'(start)) ? start + off - req_id_t'(n) : start + off;
            if (!found && i < n && valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Requester and ROM-port handshake bundle for rom_port_arbiter.
// slave is the arbiter's view, master the surrounding requesters plus ROM port.
interface rom_port_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int W_ADDR = 12,
    parameter int W_DATA = 13
);
    logic [N_REQ-1:0]             req_addr_valid;
    logic [N_REQ-1:0]             req_addr_ready;
    logic [N_REQ-1:0][W_ADDR-1:0] req_addr_data;
    logic [N_REQ-1:0]             req_data_valid;
    logic [N_REQ-1:0]             req_data_ready;
    logic signed [W_DATA-1:0]     req_data;

    logic                         rom_addr_valid;
    logic                         rom_addr_ready;
    logic [W_ADDR-1:0]            rom_addr_data;
    logic                         rom_data_valid;
    logic                         rom_data_ready;
    logic signed [W_DATA-1:0]     rom_data;

    modport slave (
        input  req_addr_valid, req_addr_data, req_data_ready,
        input  rom_addr_ready, rom_data_valid, rom_data,
        output req_addr_ready, req_data_valid, req_data,
        output rom_addr_valid, rom_addr_data, rom_data_ready
    );

    modport master (
        output req_addr_valid, req_addr_data, req_data_ready,
        output rom_addr_ready, rom_data_valid, rom_data,
        input  req_addr_ready, req_data_valid, req_data,
        input  rom_addr_valid, rom_addr_data, rom_data_ready
    );
endinterface

// File: rtl/rom_port_arbiter_tag_fifo.sv
// Tag FIFO holding the requester ID of every in-flight ROM read.
// Head is read combinationally; push when full and pop when empty are ignored.
module tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int W_PTR = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [W_PTR-1:0] wr_ptr;
    logic [W_PTR-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (W_PTR+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one in-order valid/ready ROM read port between N_REQ requesters.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int W_ADDR  = 12,
    parameter int W_DATA  = 13,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    rom_port_arbiter_if.slave        bus,
    output logic [$clog2(MAX_OUT):0] outstanding
);
    localparam int W_ID = w_id(N_REQ);

    logic [W_ID-1:0] start;
    logic [W_ID-1:0] grant;
    logic [W_ID-1:0] head;
    logic            full;
    logic            empty;
    logic            any_req;
    logic            addr_fire;
    logic            data_fire;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [W_ID-1:0] rr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (addr_fire) begin
            rr_ptr <= (grant == W_ID'(N_REQ-1)) ? '0 : grant + 1'b1;
        end
    end

    assign start = rr_ptr;
`endif

    assign grant   = W_ID'(next_grant(MAX_REQ'(bus.req_addr_valid), req_id_t'(start), N_REQ));
    assign any_req = |bus.req_addr_valid;

    // Full masks the grant outright, so a same-cycle pop never frees a slot early.
    assign bus.rom_addr_valid = any_req & ~full;
    assign bus.rom_addr_data  = bus.req_addr_data[grant];
    assign addr_fire          = bus.rom_addr_valid & bus.rom_addr_ready;

    assign bus.rom_data_ready = bus.req_data_ready[head] & ~empty;
    assign bus.req_data       = bus.rom_data;
    assign data_fire          = bus.rom_data_valid & bus.rom_data_ready;

    always_comb begin
        bus.req_addr_ready              = '0;
        bus.req_data_valid              = '0;
        bus.req_addr_ready[grant]       = bus.rom_addr_ready & ~full;
        bus.req_data_valid[head]        = bus.rom_data_valid & ~empty;
    end

    tag_fifo #(
        .DEPTH (MAX_OUT),
        .W     (W_ID)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (addr_fire),
        .pop   (data_fire),
        .din   (grant),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

    // A return with no tag in flight means the ROM port broke its contract.
    assert property (@(posedge clk) disable iff (!rst) !(bus.rom_data_valid && empty));

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed scoreboard bench for rom_port_arbiter with a one-cycle in-order ROM model.
// Build with ROM_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_rom_port_arbiter;
    localparam int N_REQ   = 2;
    localparam int W_ADDR  = 12;
    localparam int W_DATA  = 13;
    localparam int MAX_OUT = 4;

    typedef struct {
        int id;
        int data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] outstanding;

    ent_t              sb[$];
    logic [W_ADDR-1:0] rom_q[$];
    int                n_checks = 0;
    int                n_err    = 0;
    int                mdl_ptr  = 0;

    always #5 clk = ~clk;

    rom_port_arbiter_if #(.N_REQ(N_REQ), .W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

    rom_port_arbiter #(
        .N_REQ   (N_REQ),
        .W_ADDR  (W_ADDR),
        .W_DATA  (W_DATA),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .outstanding (outstanding)
    );

    function automatic int rom_word(input logic [W_ADDR-1:0] a);
        logic signed [W_DATA-1:0] w;
        w = W_DATA'(int'(a) * 3 - 52);
        return int'(w);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int st;
`ifdef ROM_ARB_FIXED_PRIO_EN
        st = 0;
`else
        st = mdl_ptr;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_addr_valid[(st + i) % N_REQ]) return (st + i) % N_REQ;
        end
        return -1;
    endfunction

    // Checks one cycle against the model, then advances the clock and the ROM model.
    task automatic tick();
        int                g;
        int                h;
        int                size0;
        logic              exp_av;
        logic              do_pop;
        logic              dut_afire;
        logic              dut_dfire;
        logic [W_ADDR-1:0] a_addr;
        #1;
        size0  = sb.size();
        do_pop = 1'b0;
        g      = model_grant();
        exp_av = (g >= 0) && (size0 < MAX_OUT);
        chk("outstanding", int'(outstanding), size0);
        if (size0 > 0) begin
            h = sb[0].id;
            chk("data_valid", int'(bus.req_data_valid), bus.rom_data_valid ? (1 << h) : 0);
            chk("rom_data_ready", int'(bus.rom_data_ready), int'(bus.req_data_ready[h]));
            if (bus.rom_data_valid && bus.req_data_ready[h]) begin
                chk("data_value", int'(bus.req_data), sb[0].data);
                do_pop = 1'b1;
            end
        end else begin
            chk("data_valid_empty", int'(bus.req_data_valid), 0);
            chk("rom_data_ready_empty", int'(bus.rom_data_ready), 0);
        end
        chk("rom_addr_valid", int'(bus.rom_addr_valid), int'(exp_av));
        if (exp_av) begin
            chk("addr_ready", int'(bus.req_addr_ready), bus.rom_addr_ready ? (1 << g) : 0);
            chk("addr_data", int'(bus.rom_addr_data), int'(bus.req_addr_data[g]));
            if (bus.rom_addr_ready) begin
                sb.push_back('{g, rom_word(bus.req_addr_data[g])});
                mdl_ptr = (g + 1) % N_REQ;
            end
        end else if (g >= 0) begin
            chk("addr_ready_full", int'(bus.req_addr_ready), 0);
        end
        dut_afire = bus.rom_addr_valid & bus.rom_addr_ready;
        dut_dfire = bus.rom_data_valid & bus.rom_data_ready;
        a_addr    = bus.rom_addr_data;
        @(posedge clk);
        if (do_pop) void'(sb.pop_front());
        if (dut_dfire && rom_q.size() > 0) void'(rom_q.pop_front());
        if (dut_afire) rom_q.push_back(a_addr);
        #1;
        bus.rom_data_valid = (rom_q.size() > 0);
        bus.rom_data       = (rom_q.size() > 0) ? W_DATA'(rom_word(rom_q[0])) : '0;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        #1;
        chk("drain_outstanding", int'(outstanding), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_addr_valid = '0;
        bus.req_addr_data  = '0;
        bus.req_data_ready = '0;
        bus.rom_addr_ready = 1'b1;
        bus.rom_data_valid = 1'b0;
        bus.rom_data       = '0;
        rst = 1'b0;
        #2;
        chk("rst_outstanding", int'(outstanding), 0);
        chk("rst_rom_data_ready", int'(bus.rom_data_ready), 0);
        chk("rst_req_data_valid", int'(bus.req_data_valid), 0);
        chk("rst_rom_addr_valid", int'(bus.rom_addr_valid), 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // basic read from requester 1
        bus.req_data_ready   = 2'b11;
        bus.req_addr_valid   = 2'b10;
        bus.req_addr_data[1] = 12'h005;
        #1;
        chk("basic_addr_ready", int'(bus.req_addr_ready), 2);
        chk("basic_rom_addr", int'(bus.rom_addr_data), 5);
        tick();
        bus.req_addr_valid = '0;
        #1;
        chk("basic_outstanding1", int'(outstanding), 1);
        chk("basic_data_valid", int'(bus.req_data_valid), 2);
        chk("basic_data", int'(bus.req_data), -37);
        tick();
        #1;
        chk("basic_outstanding0", int'(outstanding), 0);
        chk("basic_data_valid0", int'(bus.req_data_valid), 0);

        // both requesting every cycle
        bus.req_addr_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            bus.req_addr_data[0] = W_ADDR'(16 + i);
            bus.req_addr_data[1] = W_ADDR'(32 + i);
            #1;
`ifdef ROM_ARB_FIXED_PRIO_EN
            chk("fixed_grant", int'(bus.req_addr_ready), 1);
`else
            chk("rr_grant", int'(bus.req_addr_ready), (i % 2 == 0) ? 1 : 2);
`endif
            tick();
        end
        bus.req_addr_valid = '0;
        drain();

        // fill the tag FIFO with returns blocked
        bus.req_data_ready = 2'b00;
        bus.req_addr_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr_data[0] = W_ADDR'(256 + i);
            tick();
        end
        #1;
        chk("full_rom_addr_valid", int'(bus.rom_addr_valid), 0);
        chk("full_outstanding", int'(outstanding), 4);
        bus.req_data_ready = 2'b01;
        #1;
        chk("full_blocked_on_pop", int'(bus.rom_addr_valid), 0);
        tick();
        bus.req_data_ready = 2'b00;
        #1;
        chk("full_after_pop", int'(outstanding), 3);
        chk("full_regrant_valid", int'(bus.rom_addr_valid), 1);
        tick();
        #1;
        chk("full_refilled", int'(outstanding), 4);
        bus.req_addr_valid = '0;
        bus.req_data_ready = 2'b11;
        drain();

        // head-of-line block behind requester 0
        bus.req_data_ready   = 2'b10;
        bus.req_addr_valid   = 2'b01;
        bus.req_addr_data[0] = 12'h200;
        tick();
        bus.req_addr_valid   = 2'b10;
        bus.req_addr_data[1] = 12'h201;
        tick();
        bus.req_addr_valid = '0;
        #1;
        chk("hol_rom_data_ready", int'(bus.rom_data_ready), 0);
        chk("hol_r1_valid", int'(bus.req_data_valid[1]), 0);
        tick();
        tick();
        #1;
        chk("hol_still_blocked", int'(bus.req_data_valid[1]), 0);
        bus.req_data_ready = 2'b11;
        tick();
        #1;
        chk("hol_r1_released", int'(bus.req_data_valid), 2);
        drain();

        // reset with three reads in flight
        bus.req_data_ready = 2'b00;
        bus.req_addr_valid = 2'b11;
        bus.req_addr_data[0] = 12'h300;
        bus.req_addr_data[1] = 12'h301;
        tick();
        tick();
        tick();
        #1;
        chk("pre_rst_outstanding", int'(outstanding), 3);
        rst = 1'b0;
        bus.rom_data_valid = 1'b0;
        rom_q.delete();
        sb.delete();
        mdl_ptr = 0;
        #1;
        chk("mid_rst_outstanding", int'(outstanding), 0);
        chk("mid_rst_rom_data_ready", int'(bus.rom_data_ready), 0);
        chk("mid_rst_req_data_valid", int'(bus.req_data_valid), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("post_rst_grant", int'(bus.req_addr_ready), 1);
        tick();
        bus.req_addr_valid = '0;
        bus.req_data_ready = 2'b11;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares one valid/ready ROM read port (address channel in, data channel out, in-order returns) between `N_REQ` requesters, such as the stage evaluators that read the pass-value and leaf-value ROMs. A round-robin arbiter grants the address channel. A tag FIFO records the requester ID of every in-flight read so that each returned word is routed back to the requester that issued it. It sits between the evaluators and the ROM read wrapper (bram read port plus output dreg).

## Interface
- `N_REQ`, 2: number of requesters, at least 2.
- `W_ADDR`, 12: ROM address width.
- `W_DATA`, 13: ROM data width (signed).
- `MAX_OUT`, 4: maximum number of in-flight reads, which is also the tag FIFO depth. Must be a power of 2, at least 2.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-low.
- `req_addr_valid`  in  N_REQ  per-requester address valid.
- `req_addr_ready`  out  N_REQ  per-requester address accepted.
- `req_addr_data`  in  N_REQ×W_ADDR  per-requester address.
- `req_data_valid`  out  N_REQ  returned data valid, per requester.
- `req_data_ready`  in  N_REQ  requester can take data.
- `req_data`  out  W_DATA signed  returned data, broadcast to all requesters.
- `rom_addr_valid` / `rom_addr_ready` / `rom_addr_data`  out/in/out  1/1/W_ADDR  address channel to the ROM port.
- `rom_data_valid` / `rom_data_ready` / `rom_data`  in/out/in  1/1/W_DATA  data channel from the ROM port.
- `outstanding`  out  clog2(MAX_OUT)+1  number of in-flight reads.

## Operation
- **Grant.**
  - The arbiter searches from `rr_ptr` upward (with wrap) and picks the first requester with `req_addr_valid` set.
  - The search is masked off entirely while the tag FIFO is full.
- **Address forwarding.**
  - `rom_addr_valid` = (any request) & !full.
  - `rom_addr_data` = address of the granted requester.
  - `req_addr_ready[g]` = `rom_addr_ready` & !full. Every other requester sees ready = 0.
- **Address fire** (`rom_addr_valid & rom_addr_ready`):
  - push grant ID `g` into the tag FIFO;
  - set `rr_ptr` to (g+1) mod N_REQ.
- **Return routing.**
  - `h` = ID at the head of the tag FIFO.
  - `req_data_valid[h]` = `rom_data_valid` & !empty. All other `req_data_valid` bits are 0.
  - `rom_data_ready` = `req_data_ready[h]` & !empty.
  - `req_data` = `rom_data`.
- **Data fire:** pop the tag FIFO.
- **`outstanding`** = FIFO occupancy:
  - +1 on push only, −1 on pop only;
  - unchanged on simultaneous push and pop.
- **Boundary conditions.**
  - *Full:* new grants are blocked even when a pop happens in the same cycle. A push in that cycle is never performed.
  - *Empty:* `rom_data_ready` is held at 0. `rom_data_valid` while empty is a protocol violation and is flagged by an assertion.
  - *Occupancy 1 with push and pop in the same cycle:* legal; occupancy stays at 1.
  - *Requester drops `req_addr_valid` before acceptance:* the grant moves to the next requester. The requester interface requires valid to be held until accepted.
  - *A requester stalls on `req_data_ready`:* return traffic for all requesters stalls behind it. Strict in-order return is intended behaviour.
- **Reset** (asynchronous on `rst`=0):
  - FIFO empties and `rr_ptr` = 0, so `outstanding` = 0.
  - `rom_data_ready` = 0 and all `req_data_valid` = 0.
  - `rom_addr_valid` and `req_addr_ready` follow the inputs combinationally with empty-FIFO state.
  - Reset in the middle of operation discards in-flight tags. The ROM port shares the same reset, so no stale returns arrive.

## Timing
- Zero added latency on both channels: address and data paths are combinational through the arbiter.
- The only state is the tag FIFO, `rr_ptr` and occupancy. All update on the rising edge of `clk`.
- Total read latency is the ROM port latency (BRAM read plus dreg).
- Throughput: one grant per cycle. Sustained one read per cycle requires `MAX_OUT` ≥ ROM port round-trip latency + 1.
- Fairness: a continuously requesting requester waits at most N_REQ−1 grants (round-robin build).

## Configuration
- **`ROM_ARB_FIXED_PRIO_EN` defined:**
  - fixed priority, requester 0 highest;
  - `rr_ptr` is removed and the search always starts at index 0.
- **Undefined (default):** round-robin as described in Operation.
- All other behaviour is identical in both builds.

## Structure
- Shared package `rom_arb_pkg`:
  - `W_ID` = $clog2(N_REQ) constant function;
  - `req_id_t` typedef;
  - the `next_grant` priority-search function, used by both builds.
- One sub-module, `tag_fifo`:
  - `MAX_OUT`-deep × `W_ID`-bit synchronous FIFO;
  - push/pop, full/empty and count outputs;
  - head read combinationally;
  - asynchronous active-low reset.

## Test plan
- **Basic read:** N_REQ=2; requester 1 reads address 0x005 (ROM word −37) → `req_data_valid[1]` pulses with `req_data` = −37. `req_data_valid[0]` stays 0. `outstanding` goes 0→1→0.
- **Both requesting every cycle,** ROM always ready → grants alternate 0,1,0,1. Returns arrive in the same order, each on its own requester. Default build only.
- **Fixed priority:** same stimulus with `ROM_ARB_FIXED_PRIO_EN` defined → requester 0 receives every grant and requester 1 never does.
- **FIFO full:** MAX_OUT=4, `rom_data_ready` path blocked by holding `req_data_ready`=0.
  - After 4 grants, `rom_addr_valid`=0 and `outstanding`=4.
  - Releasing ready for one cycle pops 1. The next grant occurs on the following cycle, not the same one.
- **Head-of-line block:** requester 0 holds `req_data_ready`=0 with requester 1's data queued behind it → `rom_data_ready`=0 and requester 1 sees no valid until requester 0 accepts.
- **Reset mid-flight:** assert `rst`=0 with `outstanding`=3 → `outstanding`=0, `rom_data_ready`=0 and `rr_ptr`=0 immediately (asynchronous). The first grant after release goes to requester 0.
